// File: rtl/logic_op_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_issue_fifo
// Brief    : Circular operation FIFO with a registered issue stage feeding the
//            logic unit; valid/ready input side, hold/issue output side.
// Revision : 1.0 - initial release
// ============================================================================
module logic_op_issue_fifo #(
   parameter int data_size    = 8,
   parameter int op_code_size = 2,
   parameter int depth        = 4,
   parameter int addr_size    = 2
) (
   input  logic                    clk,
   input  logic                    reset_ah_in,
   input  logic [data_size-1:0]    a_in,
   input  logic [data_size-1:0]    b_in,
   input  logic [op_code_size-1:0] op_code_in,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  logic                    flush_in,
   input  logic                    hold_in,
   output logic [data_size-1:0]    a_out,
   output logic [data_size-1:0]    b_out,
   output logic [op_code_size-1:0] op_code_out,
   output logic                    issue_out,
   output logic [addr_size:0]      count_out
);

   localparam logic [addr_size:0]   c_depth   = (addr_size+1)'(depth);
   localparam logic [addr_size-1:0] c_ptr_one = addr_size'(1);

   logic [data_size-1:0]    r_mem_a  [depth];
   logic [data_size-1:0]    r_mem_b  [depth];
   logic [op_code_size-1:0] r_mem_op [depth];

   logic [addr_size-1:0]    r_wr_ptr;
   logic [addr_size-1:0]    r_rd_ptr;
   logic [addr_size:0]      r_count;
   logic [data_size-1:0]    r_a;
   logic [data_size-1:0]    r_b;
   logic [op_code_size-1:0] r_op;
   logic                    r_issue;

   logic                    w_push;
   logic                    w_pop;
   logic                    w_stage_free;
   logic [addr_size:0]      w_count_nxt;

   assign ready_out    = ~reset_ah_in & (r_count < c_depth);
   assign w_push       = valid_in & ready_out;
   // A staged op may be replaced unless the consumer is holding a valid one.
   assign w_stage_free = ~r_issue | ~hold_in;
   assign w_pop        = (r_count != '0) & w_stage_free;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Storage array carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (w_push && !flush_in) begin
         r_mem_a[r_wr_ptr]  <= a_in;
         r_mem_b[r_wr_ptr]  <= b_in;
         r_mem_op[r_wr_ptr] <= op_code_in;
      end
   end

   always_ff @(posedge clk or posedge reset_ah_in) begin
      if (reset_ah_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_issue  <= 1'b0;
      end else if (flush_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_issue  <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_a      <= r_mem_a[r_rd_ptr];
            r_b      <= r_mem_b[r_rd_ptr];
            r_op     <= r_mem_op[r_rd_ptr];
            r_issue  <= 1'b1;
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end else if (w_stage_free) begin
            r_issue  <= 1'b0;
         end
      end
   end

   assign a_out       = r_a;
   assign b_out       = r_b;
   assign op_code_out = r_op;
   assign issue_out   = r_issue;
   assign count_out   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_logic_op_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_op_issue_fifo
// Brief    : Self-checking bench for logic_op_issue_fifo using a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_op_issue_fifo;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] op;
   } op_t;

   logic       clk = 1'b0;
   logic       reset_ah_in = 1'b1;
   logic [7:0] a_in = '0;
   logic [7:0] b_in = '0;
   logic [1:0] op_code_in = '0;
   logic       valid_in = 1'b0;
   logic       flush_in = 1'b0;
   logic       hold_in = 1'b0;
   logic       ready_out;
   logic [7:0] a_out;
   logic [7:0] b_out;
   logic [1:0] op_code_out;
   logic       issue_out;
   logic [2:0] count_out;

   int passes = 0;
   int total  = 0;

   op_t q[$];
   op_t m_stage;
   logic m_issue;

   logic_op_issue_fifo #(
      .data_size(8), .op_code_size(2), .depth(4), .addr_size(2)
   ) dut (
      .clk(clk), .reset_ah_in(reset_ah_in),
      .a_in(a_in), .b_in(b_in), .op_code_in(op_code_in),
      .valid_in(valid_in), .ready_out(ready_out),
      .flush_in(flush_in), .hold_in(hold_in),
      .a_out(a_out), .b_out(b_out), .op_code_out(op_code_out),
      .issue_out(issue_out), .count_out(count_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      q.delete();
      m_stage = '0;
      m_issue = 1'b0;
   endtask

   // Next state of the model for one rising edge given the current inputs.
   task automatic model_step(input logic v, input op_t d, input logic fl, input logic hd);
      bit push, pop;
      if (fl) begin
         q.delete();
         m_issue = 1'b0;
         return;
      end
      push = v && (q.size() < 4);
      pop  = (q.size() != 0) && (!m_issue || !hd);
      if (pop) begin
         m_stage = q.pop_front();
         m_issue = 1'b1;
      end else if (!m_issue || !hd) begin
         m_issue = 1'b0;
      end
      if (push) q.push_back(d);
   endtask

   task automatic compare_all();
      chk("issue_out", 32'(issue_out), 32'(m_issue));
      chk("count_out", 32'(count_out), 32'(q.size()));
      chk("ready_out", 32'(ready_out), 32'(q.size() < 4));
      chk("a_out",     32'(a_out),     32'(m_stage.a));
      chk("b_out",     32'(b_out),     32'(m_stage.b));
      chk("op_out",    32'(op_code_out), 32'(m_stage.op));
   endtask

   // Called just after a negedge: drive, advance model, clock, compare.
   task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic fl, input logic hd);
      op_t d;
      d = '{a: a, b: b, op: op};
      valid_in = v; a_in = a; b_in = b; op_code_in = op;
      flush_in = fl; hold_in = hd;
      model_step(v, d, fl, hd);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      model_reset();
      #12;
      chk("rst_issue", 32'(issue_out), 32'd0);
      chk("rst_count", 32'(count_out), 32'd0);
      chk("rst_ready", 32'(ready_out), 32'd0);
      chk("rst_a",     32'(a_out),     32'd0);
      @(negedge clk);
      reset_ah_in = 1'b0;
      #1 chk("ready_after_rel", 32'(ready_out), 32'd1);

      // Single op latency.
      cycle(1, 8'hF0, 8'h0F, 2'b00, 0, 0);
      chk("single_nolat_issue", 32'(issue_out), 32'd0);
      cycle(0, 8'h00, 8'h00, 2'b00, 0, 0);
      chk("single_issue", 32'(issue_out), 32'd1);
      chk("single_a", 32'(a_out), 32'hF0);
      chk("single_b", 32'(b_out), 32'h0F);
      chk("single_op", 32'(op_code_out), 32'd0);
      cycle(0, 8'h00, 8'h00, 2'b00, 0, 0);
      chk("single_done", 32'(issue_out), 32'd0);

      // Fill while stalled.
      cycle(1, 8'h10, 8'h01, 2'b01, 0, 0);
      cycle(0, 8'h00, 8'h00, 2'b00, 0, 1);
      for (int i = 1; i <= 4; i++) cycle(1, 8'(8'hA0 + i), 8'(i), 2'(i), 0, 1);
      chk("full_count", 32'(count_out), 32'd4);
      chk("full_ready", 32'(ready_out), 32'd0);
      cycle(1, 8'hEE, 8'hEE, 2'b11, 0, 1);
      chk("full_reject", 32'(count_out), 32'd4);
      chk("full_hold_a", 32'(a_out), 32'h10);
      cycle(0, 8'h00, 8'h00, 2'b00, 0, 0);
      chk("rel_a1", 32'(a_out), 32'hA1);
      chk("rel_ready", 32'(ready_out), 32'd1);
      for (int i = 0; i < 4; i++) cycle(0, 8'h00, 8'h00, 2'b00, 0, 0);
      chk("drained", 32'(issue_out), 32'd0);

      // Streaming with pointer wrap.
      for (int i = 0; i < 10; i++) begin
         cycle(1, 8'(8'h30 + i), 8'(8'hC0 + i), 2'(i), 0, 0);
         chk("stream_cnt_le1", 32'(count_out <= 3'd1), 32'd1);
      end
      cycle(0, 8'h00, 8'h00, 2'b00, 0, 0);
      chk("stream_last_a", 32'(a_out), 32'h39);

      // Stall mid-stream for 3 cycles.
      cycle(1, 8'h51, 8'h15, 2'b10, 0, 0);
      cycle(1, 8'h52, 8'h25, 2'b11, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 8'h00, 8'h00, 2'b00, 0, 1);
         chk("stall_a", 32'(a_out), 32'h51);
      end
      cycle(0, 8'h00, 8'h00, 2'b00, 0, 0);
      chk("stall_next_a", 32'(a_out), 32'h52);
      cycle(0, 8'h00, 8'h00, 2'b00, 0, 0);

      // Flush with simultaneous push.
      cycle(1, 8'h61, 8'h00, 2'b00, 0, 0);
      for (int i = 2; i <= 4; i++) cycle(1, 8'(8'h60 + i), 8'h00, 2'b01, 0, 1);
      chk("preflush_count", 32'(count_out), 32'd3);
      chk("preflush_issue", 32'(issue_out), 32'd1);
      cycle(1, 8'h77, 8'h77, 2'b11, 1, 0);
      chk("flush_count", 32'(count_out), 32'd0);
      chk("flush_issue", 32'(issue_out), 32'd0);
      cycle(0, 8'h00, 8'h00, 2'b00, 0, 0);
      chk("flush_no_issue", 32'(issue_out), 32'd0);

      // Async reset between edges.
      cycle(1, 8'h81, 8'h18, 2'b01, 0, 0);
      cycle(1, 8'h82, 8'h28, 2'b10, 0, 1);
      valid_in = 1'b0; hold_in = 1'b0;
      #2 reset_ah_in = 1'b1;
      #1;
      model_reset();
      chk("arst_issue", 32'(issue_out), 32'd0);
      chk("arst_count", 32'(count_out), 32'd0);
      chk("arst_ready", 32'(ready_out), 32'd0);
      chk("arst_a",     32'(a_out),     32'd0);
      chk("arst_b",     32'(b_out),     32'd0);
      chk("arst_op",    32'(op_code_out), 32'd0);
      @(negedge clk);
      reset_ah_in = 1'b0;
      #1 chk("arst_rel_ready", 32'(ready_out), 32'd1);
      cycle(1, 8'h99, 8'h66, 2'b11, 0, 0);
      cycle(0, 8'h00, 8'h00, 2'b00, 0, 0);
      chk("arst_new_a", 32'(a_out), 32'h99);
      chk("arst_new_issue", 32'(issue_out), 32'd1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom % 4) != 0, 8'($urandom), 8'($urandom), 2'($urandom),
               ($urandom % 25) == 0, ($urandom % 3) == 0);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/logic_op_issue_fifo.md
Name: logic_op_issue_fifo

Overview:
- Operation buffer directly upstream of the registered logic unit (OR/XOR/AND/NOT on a, b).
- Accepts {a, b, op_code} from the producer under a valid/ready handshake and stores them in a circular FIFO.
- Issues one operation per clock into a registered output stage whose a_out/b_out/op_code_out drive the logic unit's a_in/b_in/op_code.
- issue_out marks the cycles that carry a real operation; hold_in lets the consumer stall issue.

Parameters:
- data_size, 8, operand width of a and b.
- op_code_size, 2, opcode width (matches logic unit encoding 00 OR, 01 XOR, 10 AND, 11 NOT a).
- depth, 4, FIFO entries; power of two, >= 2.
- addr_size, 2, log2(depth); pointer width.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset_ah_in  input  1  asynchronous, active-high reset.
- a_in  input  data_size  operand a from producer.
- b_in  input  data_size  operand b from producer.
- op_code_in  input  op_code_size  opcode from producer.
- valid_in  input  1  producer offers an operation this cycle.
- ready_out  output  1  FIFO can accept this cycle.
- flush_in  input  1  synchronous discard of all queued and staged operations.
- hold_in  input  1  consumer stall; freezes a valid output stage.
- a_out  output  data_size  staged operand a to logic unit.
- b_out  output  data_size  staged operand b to logic unit.
- op_code_out  output  op_code_size  staged opcode to logic unit.
- issue_out  output  1  output stage holds a valid operation.
- count_out  output  addr_size+1  entries in FIFO, excluding output stage.

Behaviour:
- Reset (async, while reset_ah_in=1): wr/rd pointers, count, a_out, b_out, op_code_out and issue_out = 0; ready_out = 0 while reset asserted, and 1 on the first cycle after release.
- ready_out = (count_out < depth) and not in reset; combinational from count only, never from valid_in.
- Push: on an edge with valid_in=1 and ready_out=1, entry written at wr_ptr; wr_ptr increments modulo depth (wraps depth-1 -> 0).
- Pop condition: count_out != 0 and (issue_out=0 or hold_in=0).
- On pop: head entry loads into a_out/b_out/op_code_out, issue_out <= 1, rd_ptr increments modulo depth.
- No pop and (issue_out=0 or hold_in=0): issue_out <= 0; data outputs hold their last value (no X, no clear).
- issue_out=1 and hold_in=1: output stage and rd_ptr frozen; pushes still accepted.
- Latency: push at edge N into an empty FIFO with a non-stalled output -> issue_out=1 with that data after edge N+1. No bypass path.
- Throughput: one push and one pop per cycle sustained; count_out unchanged on a simultaneous push and pop.
- Full: count_out=depth gives ready_out=0, so no push that cycle even if a pop occurs; ready_out rises the cycle after the pop.
- Empty: no pop; issue_out falls after the current staged op is released.
- Order: strict FIFO; ops issue in push order, never duplicated or dropped except by flush/reset.
- flush_in=1 at an edge: pointers and count <= 0, issue_out <= 0; any push in the same cycle is discarded. Flush has priority over push and pop.
- Reset mid-operation: all contents lost immediately, regardless of clock.
- hold_in is ignored when issue_out=0.

Test Plan:
- Reset then single op: push a=8'hF0, b=8'h0F, op=2'b00 at edge 1 -> issue_out=1 after edge 2 with a_out=F0, b_out=0F, op_code_out=00; issue_out=0 after edge 3.
- Fill while stalled: hold_in=1, one op staged, push 4 ops (A1..A4) -> count_out=4, ready_out=0; a 5th valid_in is not accepted. Release hold -> A1..A4 issue on consecutive cycles; ready_out=1 the cycle after the first pop.
- Streaming wrap: push 10 ops with op codes 00,01,10,11 repeating, hold_in=0 -> each issues exactly 1 cycle later in order; count_out stays <= 1; pointers wrap with no loss.
- Stall mid-stream: assert hold_in for 3 cycles while issue_out=1 -> a_out/b_out/op_code_out/issue_out constant for those 3 cycles; next op issues on the first edge with hold_in=0.
- Flush with simultaneous push: count_out=3, issue_out=1, then flush_in=1 and valid_in=1 -> after the edge count_out=0, issue_out=0; the pushed op never issues.
- Async reset mid-stream: assert reset_ah_in between edges -> issue_out, count_out and all outputs go to 0 immediately, ready_out=0; after release ready_out=1 and a new push issues normally.
